// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one 27-bit add/subtract core between two requesters.
// Issue register S1 feeds the combinational core; result register S2 presents its output.

module sub_nadd_27_bits (
    input  logic        sub,
    input  logic [26:0] a,
    input  logic [26:0] b,
    output logic [27:0] sum
);
    logic [26:0] b_eff;

    always_comb begin
        b_eff = sub ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {27'd0, sub};
    end
endmodule

module addsub_rr_sched #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [26:0]      req0_a,
    input  logic [26:0]      req0_b,
    input  logic             req0_sub,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [26:0]      req1_a,
    input  logic [26:0]      req1_b,
    input  logic             req1_sub,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [27:0]      res_sum,
    output logic             res_id,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic             prio_q, prio_d;
    logic [26:0]      a1_q, a1_d;
    logic [26:0]      b1_q, b1_d;
    logic             sub1_q, sub1_d;
    logic             id1_q, id1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;
    logic [27:0]      sum2_q, sum2_d;
    logic             id2_q, id2_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;

    logic             adv1, adv2;
    logic             grant0, grant1;
    logic             accept;
    logic [27:0]      core_sum;

    sub_nadd_27_bits u_core (
        .sub (sub1_q),
        .a   (a1_q),
        .b   (b1_q),
        .sum (core_sum)
    );

    // res_ready reaches the request readies combinationally so a full pipe reopens in the same cycle.
    always_comb begin
        adv2       = !v2_q || res_ready;
        adv1       = !v1_q || adv2;
        grant0     = req0_valid && (!req1_valid || !prio_q);
        grant1     = req1_valid && (!req0_valid || prio_q);
        req0_ready = !rst && adv1 && grant0;
        req1_ready = !rst && adv1 && grant1;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        v1_d   = v1_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        sub1_d = sub1_q;
        id1_d  = id1_q;
        tag1_d = tag1_q;
        prio_d = prio_q;
        v2_d   = v2_q;
        sum2_d = sum2_q;
        id2_d  = id2_q;
        tag2_d = tag2_q;

        if (adv1) begin
            v1_d = accept;
        end
        if (accept) begin
            prio_d = !prio_q;
            if (grant1) begin
                a1_d   = req1_a;
                b1_d   = req1_b;
                sub1_d = req1_sub;
                id1_d  = 1'b1;
                tag1_d = req1_tag;
            end else begin
                a1_d   = req0_a;
                b1_d   = req0_b;
                sub1_d = req0_sub;
                id1_d  = 1'b0;
                tag1_d = req0_tag;
            end
        end

        if (adv2) begin
            v2_d = v1_q;
        end
        if (v1_q && adv2) begin
            sum2_d = core_sum;
            id2_d  = id1_q;
            tag2_d = tag1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            prio_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            prio_q <= prio_d;
        end
    end

    // Payload registers are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        a1_q   <= a1_d;
        b1_q   <= b1_d;
        sub1_q <= sub1_d;
        id1_q  <= id1_d;
        tag1_q <= tag1_d;
        sum2_q <= sum2_d;
        id2_q  <= id2_d;
        tag2_q <= tag2_d;
    end

    assign res_valid = v2_q;
    assign res_sum   = sum2_q;
    assign res_id    = id2_q;
    assign res_tag   = tag2_q;
    assign busy      = v1_q || v2_q;
endmodule
